// File: rtl/piso_serial_tx.sv
// piso_serial_tx: parallel-in, serial-out frame transmitter.
// Frame = start bit (0), WIDTH data bits LSB first, optional even parity, stop bit (1).
// Each bit is held on tx_out for CLKS_PER_BIT clocks; tx_out is registered and idles high.
// Optional feature macro: SER_PARITY_EN (adds a parity bit between data and stop).
module piso_serial_tx #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             tx_out,
  output logic             busy,
  output logic             done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] TIMER_MAX = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] INDEX_MAX = IW'(WIDTH - 1);

`ifdef SER_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t           state_reg, state_next;
  logic [CW-1:0]    timer_reg, timer_next;
  logic [IW-1:0]    index_reg, index_next;
  logic [WIDTH-1:0] shreg_reg, shreg_next;
  logic             tx_out_reg, tx_out_next;
  logic             done_reg, done_next;
  logic [WIDTH-1:0] shifted;
  logic             bit_end;
`ifdef SER_PARITY_EN
  logic             parity_reg, parity_next;
`endif

  // Combinational helpers: shift-right preview and end-of-bit strobe.
  assign shifted = shreg_reg >> 1;
  assign bit_end = (timer_reg == TIMER_MAX);

  // State register and datapath registers; reset has priority over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      timer_reg  <= '0;
      index_reg  <= '0;
      shreg_reg  <= '0;
      tx_out_reg <= 1'b1;
      done_reg   <= 1'b0;
`ifdef SER_PARITY_EN
      parity_reg <= 1'b0;
`endif
    end else begin
      state_reg  <= state_next;
      timer_reg  <= timer_next;
      index_reg  <= index_next;
      shreg_reg  <= shreg_next;
      tx_out_reg <= tx_out_next;
      done_reg   <= done_next;
`ifdef SER_PARITY_EN
      parity_reg <= parity_next;
`endif
    end
  end

  // Next-state and next-output logic; the line value for the next bit is
  // computed here so tx_out changes exactly at the bit boundary edge.
  always_comb begin
    state_next  = state_reg;
    timer_next  = timer_reg;
    index_next  = index_reg;
    shreg_next  = shreg_reg;
    tx_out_next = tx_out_reg;
    done_next   = 1'b0;
`ifdef SER_PARITY_EN
    parity_next = parity_reg;
`endif
    if (state_reg != IDLE) begin
      timer_next = bit_end ? '0 : timer_reg + CW'(1);
    end
    case (state_reg)
      IDLE: begin
        tx_out_next = 1'b1;
        timer_next  = '0;
        index_next  = '0;
        if (tx_valid) begin
          shreg_next  = tx_data;
          tx_out_next = 1'b0;
          state_next  = START;
`ifdef SER_PARITY_EN
          parity_next = ^tx_data;
`endif
        end
      end
      START: begin
        if (bit_end) begin
          state_next  = DATA;
          index_next  = '0;
          tx_out_next = shreg_reg[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (index_reg == INDEX_MAX) begin
`ifdef SER_PARITY_EN
            state_next  = PARITY;
            tx_out_next = parity_reg;
`else
            state_next  = STOP;
            tx_out_next = 1'b1;
`endif
          end else begin
            index_next  = index_reg + IW'(1);
            shreg_next  = shifted;
            tx_out_next = shifted[0];
          end
        end
      end
`ifdef SER_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          state_next  = STOP;
          tx_out_next = 1'b1;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          state_next  = IDLE;
          tx_out_next = 1'b1;
          done_next   = 1'b1;
        end
      end
      default: begin
        state_next  = IDLE;
        tx_out_next = 1'b1;
      end
    endcase
  end

  assign tx_out   = tx_out_reg;
  assign done     = done_reg;
  assign tx_ready = (state_reg == IDLE);
  assign busy     = (state_reg != IDLE);

endmodule

// File: tb/tb_piso_serial_tx.sv
// tb_piso_serial_tx: directed self-checking bench for piso_serial_tx.
// Main instance WIDTH=8/CLKS_PER_BIT=4; small instance WIDTH=1/CLKS_PER_BIT=1.
// Honours SER_PARITY_EN so expected frames match the build.
module tb_piso_serial_tx;

`ifdef SER_PARITY_EN
  localparam int NB  = 11;  // 8 data + start + parity + stop
  localparam int NB1 = 4;   // 1 data + start + parity + stop
`else
  localparam int NB  = 10;
  localparam int NB1 = 3;
`endif
  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx_out, busy, done;

  logic [0:0] s_data = 1'b0;
  logic       s_valid = 1'b0;
  logic       s_ready, s_out, s_busy, s_done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  piso_serial_tx #(.WIDTH(8), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx_out(tx_out), .busy(busy), .done(done)
  );

  piso_serial_tx #(.WIDTH(1), .CLKS_PER_BIT(1)) dut_small (
    .clk(clk), .reset(reset), .tx_data(s_data), .tx_valid(s_valid),
    .tx_ready(s_ready), .tx_out(s_out), .busy(s_busy), .done(s_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected line value for bit j of a frame carrying d (hand-derived frame layout).
  function automatic logic exp_bit(input logic [7:0] d, input int j);
    if (j == 0) return 1'b0;
    if (j <= 8) return d[j-1];
`ifdef SER_PARITY_EN
    if (j == 9) return ^d;
`endif
    return 1'b1;
  endfunction

  task automatic idle_checks(input string tag);
    chk({tag, "_tx_out"}, 32'(tx_out), 32'd1);
    chk({tag, "_ready"}, 32'(tx_ready), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
  endtask

  // Called at a negedge while idle. Offers d, checks every cycle of the frame,
  // changes tx_data to data_after during the frame, then checks the done cycle.
  task automatic run_frame(input logic [7:0] d, input bit hold_valid, input logic [7:0] data_after);
    tx_data  = d;
    tx_valid = 1'b1;
    @(posedge clk);  // E0
    for (int k = 0; k < NB * CPB; k++) begin
      @(negedge clk);
      if (k == 0) begin
        tx_data = data_after;
        if (!hold_valid) tx_valid = 1'b0;
      end
      chk($sformatf("frame_%02h_bit%0d_cyc%0d", d, k / CPB, k), 32'(tx_out), 32'(exp_bit(d, k / CPB)));
      chk($sformatf("frame_%02h_busy_cyc%0d", d, k), 32'(busy), 32'd1);
      chk($sformatf("frame_%02h_ready_cyc%0d", d, k), 32'(tx_ready), 32'd0);
      chk($sformatf("frame_%02h_nodone_cyc%0d", d, k), 32'(done), 32'd0);
    end
    @(negedge clk);  // cycle after E0+N*CPB
    chk($sformatf("frame_%02h_done", d), 32'(done), 32'd1);
    chk($sformatf("frame_%02h_end_ready", d), 32'(tx_ready), 32'd1);
    chk($sformatf("frame_%02h_end_busy", d), 32'(busy), 32'd0);
    chk($sformatf("frame_%02h_end_idle_high", d), 32'(tx_out), 32'd1);
    $display("frame sent data=%02h bits=%0d", d, NB);
    if (!hold_valid) begin
      @(negedge clk);
      chk($sformatf("frame_%02h_done_one_cycle", d), 32'(done), 32'd0);
    end
  endtask

  initial begin
    // Reset, then 20 idle cycles.
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    idle_checks("reset");
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      idle_checks($sformatf("idle%0d", i));
    end

    // Single frame 0xA5 (parity build: parity 0).
    run_frame(8'hA5, 1'b0, 8'hFF);
    @(negedge clk);

    // 0x07 exercises a parity bit of 1 in the parity build.
    run_frame(8'h07, 1'b0, 8'h00);
    @(negedge clk);

    // Back-to-back with tx_valid held; data changes mid-frame must not corrupt frame 1.
    run_frame(8'h3C, 1'b1, 8'hC3);
    run_frame(8'hC3, 1'b0, 8'h00);
    @(negedge clk);

    // Reset at E0+17 aborts the frame.
    tx_data  = 8'hA5;
    tx_valid = 1'b1;
    @(posedge clk);  // E0
    for (int k = 0; k < 17; k++) begin
      @(negedge clk);
      if (k == 0) tx_valid = 1'b0;
      if (k == 16) reset = 1'b1;
    end
    @(negedge clk);  // after reset edge E0+17
    reset = 1'b0;
    idle_checks("abort");
    for (int i = 0; i < NB * CPB; i++) begin
      @(negedge clk);
      idle_checks($sformatf("abort_idle%0d", i));
    end
    $display("frame aborted by reset data=a5");

    run_frame(8'h5A, 1'b0, 8'hFF);
    @(negedge clk);

    // WIDTH=1, CLKS_PER_BIT=1, send 1.
    s_data  = 1'b1;
    s_valid = 1'b1;
    @(posedge clk);  // E0
    for (int k = 0; k < NB1; k++) begin
      @(negedge clk);
      if (k == 0) s_valid = 1'b0;
      chk($sformatf("small_bit%0d", k), 32'(s_out), (k == 0) ? 32'd0 : 32'd1);
      chk($sformatf("small_busy%0d", k), 32'(s_busy), 32'd1);
      chk($sformatf("small_nodone%0d", k), 32'(s_done), 32'd0);
    end
    @(negedge clk);
    chk("small_done", 32'(s_done), 32'd1);
    chk("small_end_ready", 32'(s_ready), 32'd1);
    chk("small_end_out", 32'(s_out), 32'd1);
    @(negedge clk);
    chk("small_done_one_cycle", 32'(s_done), 32'd0);
    $display("frame sent small data=1 bits=%0d", NB1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/piso_serial_tx.md
Name: piso_serial_tx

Overview:
Parallel-in, serial-out frame transmitter. It accepts a WIDTH-bit word over a valid/ready handshake and shifts it out on a single registered line as a frame: start bit (0), data LSB-first, optional parity, stop bit (1). Each bit is held for CLKS_PER_BIT clocks. It is the transmitting end of the serial link whose receiver captures the line through synchronizing flip-flops.

Parameters:
WIDTH, 8, data bits per frame (>=1)
CLKS_PER_BIT, 4, clock cycles each bit is held on tx_out (>=1; value 1 must work)

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
tx_data  input  WIDTH  word to send; sampled only on handshake
tx_valid  input  1  tx_data is valid
tx_ready  output  1  block can accept a word (high only in IDLE)
tx_out  output  1  serial line, registered, idles high
busy  output  1  frame in progress (any state except IDLE)
done  output  1  one-cycle pulse when a frame's stop bit completes

Behaviour:
- Reset (reset=1 at a rising edge) gives: state IDLE, tx_out=1, tx_ready=1, busy=0, done=0, and clears the shift register and counters.
- Reset mid-frame aborts the frame. tx_out=1 from the next edge and the word is discarded. Reset has priority over every other event.
- States: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
- Handshake: a word is accepted when tx_valid && tx_ready at a rising edge (call it E0). tx_data is latched into the shift register at E0. Later changes to tx_data or tx_valid are ignored until the next acceptance.
- START: tx_out=0 from E0 through E0+CLKS_PER_BIT.
- DATA: bit i is driven from E0+(i+1)*CLKS_PER_BIT for CLKS_PER_BIT cycles, i=0..WIDTH-1, LSB first. The shift register shifts right once per bit.
- STOP: tx_out=1 for CLKS_PER_BIT cycles.
- Bit timer: counts 0..CLKS_PER_BIT-1 and wraps at the end of each bit. The bit index counts 0..WIDTH-1. Counter widths are $clog2 of their range, with a minimum of 1 bit.
- Frame end: with N = frame bit count (WIDTH+2, or WIDTH+3 with parity), the state returns to IDLE at edge E0+N*CLKS_PER_BIT.
  - done=1, tx_ready=1 and busy=0 for the cycle following that edge.
  - done is high for exactly one cycle.
- Back-to-back: if tx_valid stays high, the next word is accepted at the edge after done rises. This leaves exactly one clock of idle-high between frames.
- tx_valid asserted while busy has no effect; the word is not accepted and no data is lost internally.
- tx_ready is a registered or state-decoded output with no combinational path from tx_valid.

Optional Feature:
SER_PARITY_EN
- Defined: a PARITY state is inserted between DATA and STOP. It drives the even parity (XOR of all data bits) for CLKS_PER_BIT cycles, and N = WIDTH+3.
- Not defined: the PARITY state and its logic are absent, and N = WIDTH+2.

Test Plan (WIDTH=8, CLKS_PER_BIT=4 unless stated):
- Reset then idle 20 cycles -> tx_out=1, tx_ready=1, busy=0, done=0 throughout.
- Send 0xA5 at E0 -> tx_out per 4-cycle bit: 0,1,0,1,0,0,1,0,1,1. busy high from E0 to E0+40. done is a single pulse after E0+40.
- SER_PARITY_EN defined:
  - 0xA5 -> parity bit 0 inserted before stop, done after E0+44.
  - 0x07 -> parity bit 1.
- tx_valid held high with data 0x3C then 0xC3 -> two frames separated by exactly one idle-high clock. tx_data changes during frame 1 do not corrupt it.
- Assert reset at E0+17 (mid data bit) -> tx_out=1, tx_ready=1, busy=0 after that edge. No done pulse. The next 0x5A frame is sent correctly.
- CLKS_PER_BIT=1, WIDTH=1, send 1 -> tx_out sequence 0,1,1 on consecutive cycles. done after E0+3.
